// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encoding, default operand width
// and the ordering of the datapath control bundle.
package mul_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Datapath controls, MSB first.
  typedef struct packed {
    logic ldA;
    logic ldB;
    logic ldP;
    logic clr_p;
    logic decre;
  } ctrl_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// Request, response and datapath-control bundle of the shared multiplier.
// master = arbiter side, slave = requesters plus datapath.
interface mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = mul_pkg::W_DEF
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               ldA;
  logic               ldB;
  logic               ldP;
  logic               clr_p;
  logic               decre;
  logic [W-1:0]       dp_data;
  logic               eqz;
  logic [2*W-1:0]     p_in;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [2*W-1:0]     rsp_p;

  modport master (
    input  req_valid, req_a, req_b, eqz, p_in, rsp_ready,
    output req_ready, ldA, ldB, ldP, clr_p, decre, dp_data, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    output req_valid, req_a, req_b, eqz, p_in, rsp_ready,
    input  req_ready, ldA, ldB, ldP, clr_p, decre, dp_data, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index searching upward from last+1 mod N.
// Zero latency; grants nothing when no request is valid.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int             j;
  logic [IDW-1:0] jj;

  // Walk from the farthest candidate back to the nearest so the nearest valid wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = N; k >= 1; k--) begin
      j  = (int'(last) + k) % N;
      jj = IDW'(j);
      if (valid[jj]) begin
        grant     = '0;
        grant[jj] = 1'b1;
        idx       = jj;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one repeated-addition multiplier; response B+4 cycles after accept.
// One job in flight: no request is accepted until the response handshake completes.
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = W_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  mul_arbiter_if.master bus
);

  localparam int IDW = $clog2(N_REQ);

  state_t           state_q;
  state_t           state_d;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   id_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [2*W-1:0]   p_q;
  logic [N_REQ-1:0] grant_oh;
  logic [IDW-1:0]   grant_idx;
  logic             grant_any;
  logic [N_REQ-1:0] ready;
  logic [W-1:0]     dp_data;
  logic             rsp_valid;
  ctrl_t            ctrl;

  rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
    .valid (bus.req_valid),
    .last  (last_q),
    .grant (grant_oh),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= IDW'(N_REQ - 1);
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && grant_any) begin
        a_q  <= bus.req_a[grant_idx*W +: W];
        b_q  <= bus.req_b[grant_idx*W +: W];
        id_q <= grant_idx;
      end
      if (state_q == ST_RUN && bus.eqz) p_q <= bus.p_in;
      if (state_q == ST_RESP && bus.rsp_ready) last_q <= id_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl      = '0;
    dp_data   = '0;
    ready     = '0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          ready   = grant_oh;
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        ctrl.ldA   = 1'b1;
        ctrl.clr_p = 1'b1;
        dp_data    = a_q;
        state_d    = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        ctrl.ldB = 1'b1;
        dp_data  = b_q;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (bus.eqz) begin
          state_d = ST_RESP;
        end else begin
          ctrl.ldP   = 1'b1;
          ctrl.decre = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The accept strobe is combinational from req_valid, so mask it while reset is held.
  assign bus.req_ready = reset_n ? ready : '0;
  assign bus.ldA       = ctrl.ldA;
  assign bus.ldB       = ctrl.ldB;
  assign bus.ldP       = ctrl.ldP;
  assign bus.clr_p     = ctrl.clr_p;
  assign bus.decre     = ctrl.decre;
  assign bus.dp_data   = dp_data;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = (state_q == ST_RESP) ? id_q : '0;
  assign bus.rsp_p     = p_q;

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin scheduler that shares one repeated-addition multiplier datapath (A/B/P registers, B down-counter, zero detect) among `N_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and sequences the datapath through load, accumulate and completion. It returns the product tagged with the requester index over a valid/ready response channel. It replaces a single-user start/done controller wherever several clients need the same multiplier.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 8: operand width; product width is `2*W`.
- `IDW`, `$clog2(N_REQ)`: requester-index width.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_a` in `N_REQ*W`: packed multiplicand, slice i for requester i.
- `req_b` in `N_REQ*W`: packed multiplier (iteration count), slice i.
- `req_ready` out `N_REQ`: one-hot accept strobe, at most one bit high.
- `ldA`, `ldB`, `ldP`, `clr_p`, `decre` out 1 each: datapath controls.
- `dp_data` out `W`: operand bus to the A/B registers.
- `eqz` in 1: datapath B register equals zero.
- `p_in` in `2*W`: datapath P register.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_id` out `IDW`: index of the requester that owns the response.
- `rsp_p` out `2*W`: product.

## Operation
- The FSM has five states: IDLE, LOAD_A, LOAD_B, RUN, RESP.
- **IDLE**
  - If any `req_valid` bit is high, grant the first valid index searching upward from `last_grant+1` mod `N_REQ`.
  - Drive `req_ready[grant]`=1 combinationally in the same cycle.
  - On that edge, latch `a_q`, `b_q` and `id_q`, then go to LOAD_A.
  - With no valid request, stay in IDLE with `req_ready`=0.
- **LOAD_A**: `ldA`=1, `clr_p`=1, `dp_data`=`a_q`; go to LOAD_B.
- **LOAD_B**: `ldB`=1, `dp_data`=`b_q`; go to RUN.
- **RUN**
  - If `eqz`=0: `ldP`=1, `decre`=1; stay in RUN.
  - If `eqz`=1: capture `p_in` into `rsp_p` and go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_id`=`id_q`.
  - On `rsp_valid & rsp_ready`, set `last_grant`=`id_q` and go to IDLE.
  - While stalled, `rsp_p` and `rsp_id` hold stable. No new request is accepted until the response is taken.
- **Output defaults**: every datapath control not listed for a state is 0. `dp_data`=0 outside LOAD_A and LOAD_B.
- **Width**: the product is exact because A×B < 2^(2W). The datapath adds A to P. The arbiter performs no arithmetic beyond the pointer increment mod `N_REQ`.
- **Boundary conditions**
  - `req_b`=0: RUN sees `eqz`=1 in its first cycle and the product is 0.
  - `req_a`=0: B iterations run and the product is 0.
  - A requester that drops `req_valid` before it is granted is not granted; no stickiness is required.
  - Changes to `req_a`/`req_b` after acceptance are ignored.
  - `last_grant` wraps from `N_REQ-1` to 0.
  - Illegal state encoding goes to IDLE.

## Timing
- **Reset**: `reset_n`=0 asynchronously forces:
  - state to IDLE and `last_grant` to `N_REQ-1`, so the first grant goes to index 0;
  - all outputs to 0, including `rsp_valid`, `rsp_id`, `rsp_p`, `req_ready` and all datapath controls.
- **Reset mid-operation**: the in-flight request is dropped with no response, and the datapath is not cleared by this block.
- **Latency** (acceptance edge at cycle t):
  - LOAD_A at t+1, LOAD_B at t+2.
  - RUN from t+3 to t+3+B, which is B+1 cycles.
  - `rsp_valid` rises at t+4+B.
- **Throughput**: the earliest next acceptance is the cycle after the response handshake, giving a minimum period of B+5 cycles.
- **Datapath contract**: `eqz` and `p_in` are registered datapath outputs that reflect the cycle's state. `decre` and `ldP` act on the same edge.

## Structure
- A shared package `mul_pkg` holds:
  - the state encoding (`ST_IDLE`..`ST_RESP`, 3 bits);
  - the default `W`;
  - the control-bundle ordering.
- Natural sub-module: `rr_pick`, a combinational round-robin priority picker taking (`req_valid`, `last_grant`) and returning the one-hot grant and encoded index. It is reusable by other shared-resource arbiters.
- The FSM, operand/id/product registers and output decode live in `mul_arbiter`.

## Test plan
- After reset, req0 sends A=3, B=4 with `rsp_ready`=1 → `rsp_valid` at t+8 with `rsp_p`=12 and `rsp_id`=0; `ldP`/`decre` high for exactly 4 cycles.
- req2 sends A=200, B=0 → `rsp_p`=0 at t+4; `ldP` is never asserted.
- All four requesters hold valid with B=1 → grants in order 0,1,2,3,0 with one-hot `req_ready`, and `rsp_id` follows the same sequence.
- A=255, B=255 (W=8) with `rsp_ready` held low for 5 cycles after `rsp_valid` → `rsp_p`=65025 stable throughout; `req_ready` stays 0 while req1 is valid, and req1 is granted the cycle after the handshake.
- `reset_n` asserted during RUN with A=5, B=10 → outputs 0 immediately and no response. After release, req3 is served alone → `rsp_id`=3 with the correct product.
- Only req1 valid, then req1 and req0 valid after its response → the next grant goes to req0 (wrap past `last_grant`=1 reaches 2, 3, then 0).
